// File: rtl/lock_key_if.sv
// lock_key_if: key-loader handshake between the key store side and the locked core side.
interface lock_key_if #(
    parameter int LUT_W = 4,
    parameter int XOR_W = 31
);
    logic             key_start;
    logic             key_sval;
    logic             key_sdata;
    logic             key_clear;
    logic [LUT_W-1:0] lut_key;
    logic [XOR_W-1:0] xor_key;
    logic             key_valid;
    logic             key_busy;
    logic             key_err;
    logic             key_lockout;

    modport master (
        output key_start, key_sval, key_sdata, key_clear,
        input  lut_key, xor_key, key_valid, key_busy, key_err, key_lockout
    );

    modport slave (
        input  key_start, key_sval, key_sdata, key_clear,
        output lut_key, xor_key, key_valid, key_busy, key_err, key_lockout
    );
endinterface

// File: rtl/lock_key_loader.sv
// lock_key_loader: serial key receiver for the locked c432 core, zero key until a frame is accepted.
// Define LOCK_KEY_PARITY_EN to append an even-parity bit to each frame and enable fail/lockout.
module lock_key_loader #(
    parameter int LUT_W    = 4,
    parameter int XOR_W    = 31,
    parameter int MAX_FAIL = 3
) (
    input logic       clk,
    input logic       rst_n,
    lock_key_if.slave kif
);
    localparam int KEY_W = LUT_W + XOR_W;
`ifdef LOCK_KEY_PARITY_EN
    localparam int FRAME_LEN = KEY_W + 1;
`else
    localparam int FRAME_LEN = KEY_W;
`endif
    localparam int CNT_W  = $clog2(FRAME_LEN + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SHIFT   = 3'd1;
    localparam logic [2:0] CHECK   = 3'd2;
    localparam logic [2:0] VALID   = 3'd3;
    localparam logic [2:0] LOCKOUT = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_LEN-1:0] sh_q, sh_d;
    logic [LUT_W-1:0]     lut_q, lut_d;
    logic [XOR_W-1:0]     xor_q, xor_d;
    logic [FAIL_W-1:0]    fail_q, fail_d, fail_inc;
    logic                 valid_q, valid_d, busy_q, busy_d, err_q, err_d, lock_q, lock_d;
    logic                 pass;

`ifdef LOCK_KEY_PARITY_EN
    assign pass = ~^sh_q;
`else
    assign pass = 1'b1;
`endif
    assign fail_inc = (fail_q == FAIL_W'(MAX_FAIL)) ? fail_q : fail_q + FAIL_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        lut_d   = lut_q;
        xor_d   = xor_q;
        fail_d  = fail_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        err_d   = err_q;
        lock_d  = lock_q;
        if (state_q != LOCKOUT && kif.key_clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            sh_d    = '0;
            lut_d   = '0;
            xor_d   = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b0;
        end else if (state_q inside {IDLE, SHIFT, VALID} && kif.key_start) begin
            // a restart inside SHIFT may take its first bit in the same cycle
            state_d = SHIFT;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            cnt_d   = (state_q == SHIFT && kif.key_sval) ? CNT_W'(1) : '0;
            sh_d    = (state_q == SHIFT && kif.key_sval) ? {kif.key_sdata, {(FRAME_LEN-1){1'b0}}} : '0;
        end else if (state_q == SHIFT && kif.key_sval) begin
            sh_d  = {kif.key_sdata, sh_q[FRAME_LEN-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                state_d = CHECK;
                busy_d  = 1'b0;
            end
        end else if (state_q == CHECK) begin
            lut_d   = pass ? sh_q[LUT_W-1:0] : '0;
            xor_d   = pass ? sh_q[KEY_W-1:LUT_W] : '0;
            valid_d = pass;
            err_d   = ~pass;
            fail_d  = pass ? '0 : fail_inc;
            lock_d  = ~pass && fail_inc >= FAIL_W'(MAX_FAIL);
            state_d = pass ? VALID : (lock_d ? LOCKOUT : IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            lut_q   <= '0;
            xor_q   <= '0;
            fail_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            lut_q   <= lut_d;
            xor_q   <= xor_d;
            fail_q  <= fail_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            lock_q  <= lock_d;
        end
    end

    assign kif.lut_key     = lut_q;
    assign kif.xor_key     = xor_q;
    assign kif.key_valid   = valid_q;
    assign kif.key_busy    = busy_q;
    assign kif.key_err     = err_q;
    assign kif.key_lockout = lock_q;
endmodule

// File: tb/tb_lock_key_loader.sv
// tb_lock_key_loader: directed frames with a scoreboard of expected output changes and their cycle.
module tb_lock_key_loader;
    localparam int LUT_W = 4;
    localparam int XOR_W = 31;
    localparam int KEY_W = LUT_W + XOR_W;
`ifdef LOCK_KEY_PARITY_EN
    localparam int FL = KEY_W + 1;
`else
    localparam int FL = KEY_W;
`endif

    typedef logic [37:0] snap_t;
    typedef struct {
        snap_t s;
        int    cyc;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    exp_t  q[$];
    snap_t m = '0;
    snap_t prev = '0;
    snap_t mon_s;
    exp_t  mon_e;
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    fails = 0;

    localparam logic [3:0]  LA = 4'hA;
    localparam logic [30:0] XA = 31'h2A5A5A5A;
    localparam logic [3:0]  LB = 4'h5;
    localparam logic [30:0] XB = 31'h12345678;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lock_key_if #(.LUT_W(LUT_W), .XOR_W(XOR_W)) kif ();

    lock_key_loader #(.LUT_W(LUT_W), .XOR_W(XOR_W), .MAX_FAIL(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    function automatic snap_t mk(input logic v, input logic e, input logic l,
                                 input logic [3:0] lu, input logic [30:0] x);
        return {v, e, l, lu, x};
    endfunction

    task automatic expect_at(input snap_t s, input int c);
        if (s !== m) begin
            q.push_back('{s, c});
            m = s;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        mon_s = {kif.key_valid, kif.key_err, kif.key_lockout, kif.lut_key, kif.xor_key};
        if (mon_s !== prev) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: got %h at cycle %0d expected no change", mon_s, cyc);
            end else begin
                mon_e = q.pop_front();
                if (mon_s !== mon_e.s || (mon_e.cyc >= 0 && mon_e.cyc != cyc)) begin
                    errors++;
                    $display("FAIL scoreboard: got %h at cycle %0d expected %h at cycle %0d",
                             mon_s, cyc, mon_e.s, mon_e.cyc);
                end
            end
            prev = mon_s;
        end
    end

    task automatic start_frame();
        expect_at({m[37], 1'b0, m[35:0]}, cyc + 1);
        kif.key_start = 1'b1;
        @(negedge clk);
        kif.key_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        kif.key_sval  = 1'b1;
        kif.key_sdata = b;
        @(negedge clk);
        kif.key_sval  = 1'b0;
        kif.key_sdata = ~b;
    endtask

    task automatic send_frame(input logic [3:0] l, input logic [30:0] x, input logic goodpar, input bit gap);
        logic [FL-1:0] f;
        logic          pass;
        f[KEY_W-1:0] = {x, l};
`ifdef LOCK_KEY_PARITY_EN
        f[KEY_W] = (^{x, l}) ^ ~goodpar;
        pass = goodpar;
`else
        pass = 1'b1;
`endif
        start_frame();
        chk("busy_rise", kif.key_busy, 1);
        for (int i = 0; i < FL; i++) begin
            if (i == FL - 1) begin
                if (pass) begin
                    fails = 0;
                    expect_at(mk(1'b1, 1'b0, 1'b0, l, x), cyc + 2);
                end else begin
                    fails = (fails < 3) ? fails + 1 : 3;
                    expect_at(mk(1'b0, 1'b1, fails >= 3, '0, '0), cyc + 2);
                end
            end
            send_bit(f[i]);
            if (gap && i < FL - 1) @(negedge clk);
        end
        chk("busy_fall", kif.key_busy, 0);
    endtask

    task automatic do_clear(input logic with_start);
        expect_at(mk(1'b0, 1'b0, m[35], '0, '0), cyc + 1);
        kif.key_clear = 1'b1;
        kif.key_start = with_start;
        @(negedge clk);
        kif.key_clear = 1'b0;
        kif.key_start = 1'b0;
        chk("clear_busy", kif.key_busy, 0);
    endtask

    task automatic async_reset();
        expect_at('0, -1);
        fails = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", kif.key_valid, 0);
        chk("arst_lut", kif.lut_key, 0);
        chk("arst_xor", kif.xor_key, 0);
        chk("arst_busy", kif.key_busy, 0);
        chk("arst_err", kif.key_err, 0);
        chk("arst_lock", kif.key_lockout, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        kif.key_start = 1'b0;
        kif.key_sval  = 1'b0;
        kif.key_sdata = 1'b0;
        kif.key_clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", kif.key_valid, 0);
        chk("rst_lut", kif.lut_key, 0);
        chk("rst_xor", kif.xor_key, 0);
        chk("rst_busy", kif.key_busy, 0);
        chk("rst_err", kif.key_err, 0);
        chk("rst_lock", kif.key_lockout, 0);
        rst_n = 1'b1;
        @(negedge clk);

        send_frame(LA, XA, 1'b1, 1'b0);
        @(negedge clk);
        chk("good_valid", kif.key_valid, 1);
        chk("good_lut", kif.lut_key, 4'hA);
        chk("good_xor", kif.xor_key, 31'h2A5A5A5A);
        chk("good_err", kif.key_err, 0);

        do_clear(1'b0);
        send_frame(LA, XA, 1'b1, 1'b1);
        @(negedge clk);
        chk("gap_lut", kif.lut_key, 4'hA);
        chk("gap_xor", kif.xor_key, 31'h2A5A5A5A);

        start_frame();
        for (int i = 0; i < 20; i++) send_bit(i[0]);
        chk("reload_valid_held", kif.key_valid, 1);
        chk("reload_lut_held", kif.lut_key, 4'hA);
        send_frame(LB, XB, 1'b1, 1'b0);
        @(negedge clk);
        chk("restart_lut", kif.lut_key, 4'h5);
        chk("restart_xor", kif.xor_key, 31'h12345678);

        do_clear(1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        chk("idle_sval_ignored", kif.key_busy, 0);

        start_frame();
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        do_clear(1'b0);
        send_frame(LB, XB, 1'b1, 1'b0);

        start_frame();
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        async_reset();
        send_frame(LA, XA, 1'b1, 1'b0);
        @(negedge clk);
        chk("post_rst_valid", kif.key_valid, 1);

`ifdef LOCK_KEY_PARITY_EN
        send_frame(LA, XA, 1'b0, 1'b0);
        @(negedge clk);
        chk("bad_err", kif.key_err, 1);
        chk("bad_valid", kif.key_valid, 0);
        chk("bad_lut", kif.lut_key, 0);
        send_frame(LA, XA, 1'b0, 1'b0);
        send_frame(LA, XA, 1'b0, 1'b0);
        @(negedge clk);
        chk("lockout_set", kif.key_lockout, 1);
        kif.key_start = 1'b1;
        @(negedge clk);
        kif.key_start = 1'b0;
        chk("lockout_start_ignored", kif.key_busy, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        chk("lockout_held", kif.key_lockout, 1);
        async_reset();
        send_frame(LA, XA, 1'b1, 1'b0);
        @(negedge clk);
        chk("unlock_valid", kif.key_valid, 1);
`endif

        repeat (4) @(negedge clk);
        chk("queue_drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
